// File: rtl/vga_timing_pkg.sv
// Shared VGA timing defaults, filter mode encodings and pipeline flag layout.
// Pure definitions; no latency or backpressure of its own.
package vga_timing_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_RUN    = 2'd2,
        MODE_EDGE   = 2'd3
    } mode_t;

    // Raw scan flags; syncs are active-high here and inverted at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic fs;
        logic active;
        logic win;
        logic first;
    } scan_flags_t;

    // One cycle for the address register, RD_LAT for the BRAM, one for the pixel register.
    function automatic int lat(input int rd_lat);
        return rd_lat + 2;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v scan counters with raw sync, active-area and image-window flags.
// Flags are combinational from the current count; no backpressure.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480,
    parameter int IMG_X0   = 0,
    parameter int IMG_Y0   = 0,
    parameter int H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic [H_W-1:0] h,
    output logic [V_W-1:0] v,
    output logic           raw_hs,
    output logic           raw_vs,
    output logic           active,
    output logic           in_win
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    int hi;
    int vi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h == H_W'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == V_W'(V_TOTAL - 1)) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    always_comb begin
        hi     = int'(h);
        vi     = int'(v);
        raw_hs = (hi >= H_ACTIVE + H_FP) && (hi < H_ACTIVE + H_FP + H_SYNC);
        raw_vs = (vi >= V_ACTIVE + V_FP) && (vi < V_ACTIVE + V_FP + V_SYNC);
        active = (hi < H_ACTIVE) && (vi < V_ACTIVE);
        in_win = active && (hi >= IMG_X0) && (hi < IMG_X0 + IMG_W)
                        && (vi >= IMG_Y0) && (vi < IMG_Y0 + IMG_H);
    end

endmodule

// File: rtl/vga_frame_scanner.sv
// VGA scan engine: framebuffer address generation, BRAM latency alignment, per-line pixel filter.
// Latency RD_LAT+2 cycles from scan position to pins; free-running, no backpressure.
module vga_frame_scanner
    import vga_timing_pkg::*;
#(
    parameter int         H_ACTIVE = H_ACTIVE_DEF,
    parameter int         H_FP     = H_FP_DEF,
    parameter int         H_SYNC   = H_SYNC_DEF,
    parameter int         H_BP     = H_BP_DEF,
    parameter int         V_ACTIVE = V_ACTIVE_DEF,
    parameter int         V_FP     = V_FP_DEF,
    parameter int         V_SYNC   = V_SYNC_DEF,
    parameter int         V_BP     = V_BP_DEF,
    parameter int         IMG_W    = 640,
    parameter int         IMG_H    = 480,
    parameter int         IMG_X0   = 0,
    parameter int         IMG_Y0   = 0,
    parameter int         ADDR_W   = 19,
    parameter int         RD_LAT   = 1,
    parameter int         RUN_LEN  = 2,
    parameter logic [2:0] BORDER   = 3'b000
) (
    input  logic              VGA_CLK,
    input  logic              RST_N,
    input  logic [1:0]        mode,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data,
    output logic [2:0]        pixel,
    output logic              vga_h_sync,
    output logic              vga_v_sync,
    output logic              frame_start
);

    localparam int LAT   = lat(RD_LAT);
    localparam int H_W   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_W   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int RUN_W = $clog2(RUN_LEN + 1);

    if (IMG_X0 + IMG_W > H_ACTIVE || IMG_Y0 + IMG_H > V_ACTIVE) begin : g_bad_window
        $error("vga_frame_scanner: image window exceeds the active area");
    end

    logic [H_W-1:0] h;
    logic [V_W-1:0] v;
    logic           raw_hs;
    logic           raw_vs;
    logic           active;
    logic           in_win;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .IMG_W(IMG_W), .IMG_H(IMG_H), .IMG_X0(IMG_X0), .IMG_Y0(IMG_Y0),
        .H_W(H_W), .V_W(V_W)
    ) u_timing (
        .clk    (VGA_CLK),
        .rst_n  (RST_N),
        .h      (h),
        .v      (v),
        .raw_hs (raw_hs),
        .raw_vs (raw_vs),
        .active (active),
        .in_win (in_win)
    );

    logic              frame_origin;
    logic [ADDR_W-1:0] addr_cnt;
    logic [ADDR_W-1:0] addr_base;
    mode_t             mode_q;
    scan_flags_t       cur;
    scan_flags_t       dly [LAT-1];
    scan_flags_t       f;

    assign frame_origin = (h == '0) && (v == '0);
    // Clearing at the frame origin is folded in so a window anchored at (0,0) still reads address 0.
    assign addr_base    = frame_origin ? '0 : addr_cnt;

    always_comb begin
        cur.hs     = raw_hs;
        cur.vs     = raw_vs;
        cur.fs     = frame_origin;
        cur.active = active;
        cur.win    = in_win;
        cur.first  = in_win && (int'(h) == IMG_X0);
    end

    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            addr_cnt <= '0;
            mem_addr <= '0;
            mode_q   <= MODE_PASS;
            for (int i = 0; i < LAT - 1; i++) dly[i] <= '0;
        end else begin
            if (in_win) begin
                mem_addr <= addr_base;
                addr_cnt <= addr_base + 1'b1;
            end else begin
                addr_cnt <= addr_base;
            end
            if (frame_origin) mode_q <= mode_t'(mode);
            dly[0] <= cur;
            for (int i = 1; i < LAT - 1; i++) dly[i] <= dly[i-1];
        end
    end

    // Last delay stage lines up with mem_data; the output registers form the final stage.
    assign f = dly[LAT-2];

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_base;
    logic [RUN_W-1:0] run_next;
    logic             prev;
    logic             prev_base;
    logic [2:0]       win_pix;

    always_comb begin
        run_base  = f.first ? '0 : run_cnt;
        prev_base = f.first ? 1'b0 : prev;
        if (!mem_data)
            run_next = '0;
        else if (run_base >= RUN_W'(RUN_LEN))
            run_next = RUN_W'(RUN_LEN);
        else
            run_next = run_base + 1'b1;
        win_pix = 3'b000;
        case (mode_q)
            MODE_PASS:   win_pix = {3{mem_data}};
            MODE_INVERT: win_pix = {3{~mem_data}};
            MODE_RUN:    win_pix = (run_next >= RUN_W'(RUN_LEN)) ? 3'b111 : 3'b000;
            MODE_EDGE:   win_pix = (mem_data != prev_base) ? 3'b111 : 3'b000;
        endcase
    end

    always_ff @(posedge VGA_CLK) begin
        if (!RST_N) begin
            pixel       <= 3'b000;
            vga_h_sync  <= 1'b1;
            vga_v_sync  <= 1'b1;
            frame_start <= 1'b0;
            run_cnt     <= '0;
            prev        <= 1'b0;
        end else begin
            vga_h_sync  <= ~f.hs;
            vga_v_sync  <= ~f.vs;
            frame_start <= f.fs;
            if (!f.active)
                pixel <= 3'b000;
            else if (!f.win)
                pixel <= BORDER;
            else
                pixel <= win_pix;
            if (f.win) begin
                run_cnt <= run_next;
                prev    <= mem_data;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_scanner.sv
// Scoreboard bench: a per-pixel reference model feeds expected-output queues; a monitor compares each cycle.
module tb_vga_frame_scanner;

    localparam int         HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int         VA = 10, VF = 1, VS = 2, VB = 2;
    localparam int         HT = HA + HF + HS + HB;
    localparam int         VT = VA + VF + VS + VB;
    localparam int         W = 8, H = 6, X0 = 5, Y0 = 2;
    localparam int         ADDR_W = 6, RD_LAT = 3, RUN_LEN = 2;
    localparam logic [2:0] BORDER = 3'b001;
    localparam int         LAT = RD_LAT + 2;
    localparam int         NPIX = W * H;
    localparam int         FRAME = HT * VT;

    typedef struct packed {
        logic [2:0] pix;
        logic       hs;
        logic       vs;
        logic       fs;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        mode;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_data;
    logic [2:0]        pixel;
    logic              hs;
    logic              vs;
    logic              fs;

    always #5 clk = ~clk;

    vga_frame_scanner #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .IMG_W(W), .IMG_H(H), .IMG_X0(X0), .IMG_Y0(Y0),
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .RUN_LEN(RUN_LEN), .BORDER(BORDER)
    ) dut (
        .VGA_CLK     (clk),
        .RST_N       (rst_n),
        .mode        (mode),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .pixel       (pixel),
        .vga_h_sync  (hs),
        .vga_v_sync  (vs),
        .frame_start (fs)
    );

    // BRAM model: data for an address appears RD_LAT cycles after the address.
    logic              img [NPIX];
    logic [RD_LAT-1:0] rd_pipe = '0;

    always @(posedge clk)
        rd_pipe <= {rd_pipe[RD_LAT-2:0], (int'(mem_addr) < NPIX) ? img[int'(mem_addr)] : 1'b0};
    assign mem_data = rd_pipe[RD_LAT-1];

    exp_t              exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int                checks = 0;
    int                errors = 0;
    bit                checking = 0;
    int                n;
    int                frame_cnt = 0;
    int                frame_mode = 0;
    logic [ADDR_W-1:0] last_addr;

    function automatic bit in_window(input int h, input int v);
        return h >= X0 && h < X0 + W && v >= Y0 && v < Y0 + H;
    endfunction

    // Expected pins for scan position (h,v), computed from the image directly.
    function automatic exp_t model(input int h, input int v, input int md);
        exp_t e;
        int   x, y, base, run;
        logic d, p;
        e.hs  = !(h >= HA + HF && h < HA + HF + HS);
        e.vs  = !(v >= VA + VF && v < VA + VF + VS);
        e.fs  = (h == 0 && v == 0);
        e.pix = 3'b000;
        if (h < HA && v < VA) begin
            if (in_window(h, v)) begin
                x    = h - X0;
                y    = v - Y0;
                base = y * W;
                d    = img[base + x];
                case (md)
                    0: e.pix = {3{d}};
                    1: e.pix = {3{~d}};
                    2: begin
                        run = 0;
                        for (int i = x; i >= 0 && img[base + i]; i--) run++;
                        e.pix = (run >= RUN_LEN) ? 3'b111 : 3'b000;
                    end
                    default: begin
                        p = 1'b0;
                        if (x > 0) p = img[base + x - 1];
                        e.pix = (d != p) ? 3'b111 : 3'b000;
                    end
                endcase
            end else begin
                e.pix = BORDER;
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, req);
        end
    endtask

    // Called at a negedge: the following posedge is a reset edge.
    task automatic apply_reset();
        rst_n = 1'b0;
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i < LAT; i++) exp_q.push_back('{pix: 3'b000, hs: 1'b1, vs: 1'b1, fs: 1'b0});
        addr_q.push_back('0);
        last_addr = '0;
        n         = 0;
        checking  = 1'b1;
        @(negedge clk);
    endtask

    task automatic step();
        int h, v;
        rst_n = 1'b1;
        h = n % HT;
        v = (n / HT) % VT;
        if (h == 0 && v == 5) mode = 2'(frame_cnt % 4);
        if ($urandom_range(0, 149) == 0) mode = 2'($urandom_range(0, 3));
        if (h == 0 && v == 0) begin
            frame_cnt++;
            frame_mode = int'(mode);
            for (int a = 0; a < NPIX; a++)
                img[a] = (frame_cnt == 1) ? a[0] : 1'($urandom_range(0, 1));
        end
        exp_q.push_back(model(h, v, frame_mode));
        if (h < HA && v < VA && in_window(h, v)) last_addr = ADDR_W'((v - Y0) * W + (h - X0));
        addr_q.push_back(last_addr);
        n++;
        @(negedge clk);
    endtask

    initial begin
        exp_t              e;
        logic [ADDR_W-1:0] a;
        forever begin
            @(posedge clk);
            #1;
            if (checking) begin
                if (exp_q.size() == 0 || addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard at t=%0t: got empty queue, expected pending entry", $time);
                end else begin
                    e = exp_q.pop_front();
                    a = addr_q.pop_front();
                    check("pixel", int'(pixel), int'(e.pix));
                    check("h_sync", int'(hs), int'(e.hs));
                    check("v_sync", int'(vs), int'(e.vs));
                    check("frame_start", int'(fs), int'(e.fs));
                    check("mem_addr", int'(mem_addr), int'(a));
                end
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        mode      = 2'd0;
        last_addr = '0;
        n         = 0;
        for (int a = 0; a < NPIX; a++) img[a] = 1'b0;
        repeat (4) @(negedge clk);
        apply_reset();
        for (int i = 0; i < 3 * FRAME + 50; i++) step();
        // Reset in the middle of a window line, then keep scanning.
        while (n % FRAME != 4 * HT + 9) step();
        apply_reset();
        for (int i = 0; i < 5 * FRAME + 20; i++) step();
        checking = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
